// File: rtl/bp_fe_queue_ckpt_fifo_pkg.sv
// FE->BE queue message types and configuration helpers shared by the checkpoint FIFO.
package bp_fe_queue_ckpt_fifo_pkg;

  typedef enum logic [1:0] {
    e_bp_inv_cfg     = 2'd0,
    e_bp_default_cfg = 2'd1
  } bp_params_e;

  localparam int vaddr_width_gp               = 39;
  localparam int branch_metadata_fwd_width_gp = 35;
  localparam int instr_width_gp               = 32;

  typedef enum logic [1:0] {
    e_fe_fetch     = 2'b00,
    e_fe_exception = 2'b01
  } bp_fe_queue_type_e;

  typedef struct packed {
    bp_fe_queue_type_e                        msg_type;
    logic [vaddr_width_gp-1:0]                pc;
    logic [instr_width_gp-1:0]                instr;
    logic [branch_metadata_fwd_width_gp-1:0]  branch_metadata_fwd;
  } bp_fe_queue_s;

  // Every currently supported configuration shares one FE message geometry.
  function automatic int bp_vaddr_width(bp_params_e cfg);
    return (cfg == e_bp_default_cfg) ? vaddr_width_gp : vaddr_width_gp;
  endfunction

  function automatic int bp_branch_metadata_fwd_width(bp_params_e cfg);
    return (cfg == e_bp_default_cfg) ? branch_metadata_fwd_width_gp : branch_metadata_fwd_width_gp;
  endfunction

  function automatic int bp_fe_queue_width(int vaddr_width, int branch_metadata_fwd_width);
    return $bits(bp_fe_queue_type_e) + vaddr_width + instr_width_gp + branch_metadata_fwd_width;
  endfunction

endpackage

// File: rtl/bp_fe_queue_ckpt_fifo_mem.sv
// 1R1W storage, synchronous write, asynchronous read (0-cycle read latency).
module bp_fe_queue_ckpt_fifo_mem #(
  parameter int width_p = 8,
  parameter int els_p   = 8,
  localparam int addr_width_lp = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem [els_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      mem[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem[r_addr_i];

endmodule

// File: rtl/bp_fe_queue_ckpt_fifo.sv
// FE queue with speculative read pointer and commit checkpoint; 1-cycle enqueue-to-valid, no bypass.
// ready drops when els_p entries are uncommitted; read-but-uncommitted entries are kept for replay.
module bp_fe_queue_ckpt_fifo
  import bp_fe_queue_ckpt_fifo_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_inv_cfg,
  parameter int els_p = 8,
  localparam int vaddr_width_p = bp_vaddr_width(bp_params_p),
  localparam int branch_metadata_fwd_width_p = bp_branch_metadata_fwd_width(bp_params_p),
  localparam int fe_queue_width_lp = bp_fe_queue_width(vaddr_width_p, branch_metadata_fwd_width_p),
  localparam int ptr_width_lp = $clog2(els_p) + 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,

  input  logic [fe_queue_width_lp-1:0] fe_queue_i,
  input  logic                         fe_queue_v_i,
  output logic                         fe_queue_ready_o,

  output logic [fe_queue_width_lp-1:0] fe_queue_o,
  output logic                         fe_queue_v_o,
  input  logic                         fe_queue_yumi_i,
  input  logic                         fe_queue_clr_i,
  input  logic                         fe_queue_roll_i,
  input  logic                         fe_queue_deq_i,

  output logic [ptr_width_lp-1:0]      occupancy_o
);

  typedef logic [ptr_width_lp-1:0] ptr_t;

  localparam ptr_t full_xor_lp = ptr_t'(els_p);

  ptr_t wptr, rptr, cptr;
  ptr_t wptr_n, rptr_n, cptr_n;

  logic full, enq, yumi_ok, deq_ok;

  assign full             = ((wptr ^ cptr) == full_xor_lp);
  assign fe_queue_ready_o = ~full & ~reset_i;
  assign fe_queue_v_o     = (rptr != wptr);
  assign occupancy_o      = wptr - cptr;

  assign enq     = fe_queue_v_i & fe_queue_ready_o & ~fe_queue_clr_i;
  assign yumi_ok = fe_queue_yumi_i & fe_queue_v_o & ~fe_queue_roll_i;
  // Committing is only legal on an entry already read, counting this cycle's read.
  assign deq_ok  = fe_queue_deq_i & (cptr != (rptr + ptr_t'(yumi_ok)));

  always_comb begin
    wptr_n = wptr + ptr_t'(enq);
    cptr_n = cptr + ptr_t'(deq_ok);
    rptr_n = fe_queue_roll_i ? cptr_n : (rptr + ptr_t'(yumi_ok));
    if (fe_queue_clr_i) begin
      wptr_n = wptr;
      cptr_n = wptr;
      rptr_n = wptr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr <= '0;
      rptr <= '0;
      cptr <= '0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
      cptr <= cptr_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && !fe_queue_clr_i) begin
      assert (!(fe_queue_yumi_i && !fe_queue_v_o));
      assert (!(fe_queue_deq_i && !deq_ok));
    end
  end

  bp_fe_queue_ckpt_fifo_mem #(
    .width_p (fe_queue_width_lp),
    .els_p   (els_p)
  ) mem (
    .clk_i    (clk_i),
    .w_v_i    (enq),
    .w_addr_i (wptr[ptr_width_lp-2:0]),
    .w_data_i (fe_queue_i),
    .r_addr_i (rptr[ptr_width_lp-2:0]),
    .r_data_o (fe_queue_o)
  );

endmodule

// File: tb/tb_bp_fe_queue_ckpt_fifo.sv
// Bench for the checkpoint FE queue: queue-based reference model plus directed scenarios.
module tb_bp_fe_queue_ckpt_fifo;
  import bp_fe_queue_ckpt_fifo_pkg::*;

  localparam int W   = $bits(bp_fe_queue_s);
  localparam int ELS = 8;

  logic         clk = 1'b0;
  logic         reset_i;
  logic [W-1:0] fe_queue_i;
  logic         fe_queue_v_i;
  logic         fe_queue_ready_o;
  logic [W-1:0] fe_queue_o;
  logic         fe_queue_v_o;
  logic         fe_queue_yumi_i;
  logic         fe_queue_clr_i;
  logic         fe_queue_roll_i;
  logic         fe_queue_deq_i;
  logic [3:0]   occupancy_o;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  bp_fe_queue_ckpt_fifo #(.els_p(ELS)) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .fe_queue_i       (fe_queue_i),
    .fe_queue_v_i     (fe_queue_v_i),
    .fe_queue_ready_o (fe_queue_ready_o),
    .fe_queue_o       (fe_queue_o),
    .fe_queue_v_o     (fe_queue_v_o),
    .fe_queue_yumi_i  (fe_queue_yumi_i),
    .fe_queue_clr_i   (fe_queue_clr_i),
    .fe_queue_roll_i  (fe_queue_roll_i),
    .fe_queue_deq_i   (fe_queue_deq_i),
    .occupancy_o      (occupancy_o)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: entries from the commit point onward, and how many of them have been read.
  bp_fe_queue_s mq[$];
  int  rd      = 0;
  bit  started = 0;
  bit  m_acc, m_yumi;
  int  m_nrd;

  always @(posedge clk) begin
    if (reset_i) begin
      mq.delete();
      rd = 0;
      started = 1;
    end else if (started) begin
      if (fe_queue_clr_i) begin
        mq.delete();
        rd = 0;
      end else begin
        m_acc  = fe_queue_v_i && (mq.size() < ELS);
        m_yumi = fe_queue_yumi_i && !fe_queue_roll_i && (rd < mq.size());
        m_nrd  = rd + int'(m_yumi);
        if (fe_queue_deq_i) begin
          void'(mq.pop_front());
          m_nrd--;
        end
        if (fe_queue_roll_i) m_nrd = 0;
        if (m_acc) mq.push_back(bp_fe_queue_s'(fe_queue_i));
        rd = m_nrd;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("m_ready", {127'b0, fe_queue_ready_o}, {127'b0, (mq.size() < ELS) && !reset_i});
      check("m_v", {127'b0, fe_queue_v_o}, {127'b0, rd < mq.size()});
      check("m_occ", 128'(occupancy_o), 128'(mq.size()));
      check("m_occ_bound", {127'b0, occupancy_o <= 4'd8}, 128'd1);
      if (rd < mq.size()) check("m_data", 128'(fe_queue_o), 128'(mq[rd]));
    end
  end

  function automatic bp_fe_queue_s make(input logic [38:0] pc);
    bp_fe_queue_s m;
    m.msg_type            = e_fe_fetch;
    m.pc                  = pc;
    m.instr               = pc[31:0] ^ 32'h0000_0013;
    m.branch_metadata_fwd = {pc[34:0]} ^ 35'h5_5555_5555;
    return m;
  endfunction

  function automatic logic [127:0] out_pc();
    bp_fe_queue_s m;
    m = bp_fe_queue_s'(fe_queue_o);
    return 128'(m.pc);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fe_queue_v_i    = 1'b0;
    fe_queue_yumi_i = 1'b0;
    fe_queue_clr_i  = 1'b0;
    fe_queue_roll_i = 1'b0;
    fe_queue_deq_i  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fails++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $fatal(1, "timeout");
  end

  int produced, consumed;

  initial begin
    reset_i    = 1'b1;
    fe_queue_i = '0;
    idle_inputs();
    repeat (2) tick();
    check("rst_ready", {127'b0, fe_queue_ready_o}, 128'd0);
    check("rst_v", {127'b0, fe_queue_v_o}, 128'd0);
    check("rst_occ", 128'(occupancy_o), 128'd0);
    reset_i = 1'b0;
    #1;
    check("ready_after_rst", {127'b0, fe_queue_ready_o}, 128'd1);

    // Fill to depth, then hold a ninth request.
    for (int i = 0; i < 8; i++) begin
      fe_queue_v_i = 1'b1;
      fe_queue_i   = make(39'h8000_0000 + 39'(4 * i));
      tick();
    end
    check("full_ready", {127'b0, fe_queue_ready_o}, 128'd0);
    check("full_occ", 128'(occupancy_o), 128'd8);
    fe_queue_i = make(39'h8000_0020);
    repeat (2) tick();
    check("ninth_held", 128'(occupancy_o), 128'd8);

    // Read three, roll back to the checkpoint.
    for (int i = 0; i < 3; i++) begin
      check("spec_pc", out_pc(), 128'h8000_0000 + 128'(4 * i));
      fe_queue_yumi_i = 1'b1;
      tick();
      fe_queue_yumi_i = 1'b0;
    end
    fe_queue_roll_i = 1'b1;
    tick();
    fe_queue_roll_i = 1'b0;
    check("roll_pc", out_pc(), 128'h8000_0000);
    check("roll_occ", 128'(occupancy_o), 128'd8);

    // Read two, then commit one while rolling.
    for (int i = 0; i < 2; i++) begin
      check("reread_pc", out_pc(), 128'h8000_0000 + 128'(4 * i));
      fe_queue_yumi_i = 1'b1;
      tick();
      fe_queue_yumi_i = 1'b0;
    end
    fe_queue_deq_i  = 1'b1;
    fe_queue_roll_i = 1'b1;
    tick();
    fe_queue_deq_i  = 1'b0;
    fe_queue_roll_i = 1'b0;
    check("deqroll_pc", out_pc(), 128'h8000_0004);
    check("deqroll_occ", 128'(occupancy_o), 128'd7);
    check("deqroll_ready", {127'b0, fe_queue_ready_o}, 128'd1);
    tick();
    fe_queue_v_i = 1'b0;
    check("ninth_accepted", 128'(occupancy_o), 128'd8);

    // Drop to five resident, then clear with everything else asserted.
    for (int i = 0; i < 3; i++) begin
      fe_queue_yumi_i = 1'b1;
      fe_queue_deq_i  = 1'b1;
      tick();
    end
    idle_inputs();
    check("five_occ", 128'(occupancy_o), 128'd5);
    fe_queue_clr_i  = 1'b1;
    fe_queue_v_i    = 1'b1;
    fe_queue_i      = make(39'h0_dead_0000);
    fe_queue_yumi_i = 1'b1;
    fe_queue_deq_i  = 1'b1;
    tick();
    idle_inputs();
    check("clr_v", {127'b0, fe_queue_v_o}, 128'd0);
    check("clr_occ", 128'(occupancy_o), 128'd0);
    check("clr_ready", {127'b0, fe_queue_ready_o}, 128'd1);
    tick();
    check("clr_enq_absent", {127'b0, fe_queue_v_o}, 128'd0);

    // Streaming rounds across the pointer wrap.
    produced = 0;
    consumed = 0;
    for (int k = 0; k < 20; k++) begin
      idle_inputs();
      if ((k % 3) != 2) begin
        fe_queue_v_i = 1'b1;
        fe_queue_i   = make(39'h9000_0000 + 39'(4 * produced));
        produced++;
      end
      if (rd < mq.size()) begin
        check("stream_pc", out_pc(), 128'h9000_0000 + 128'(4 * consumed));
        fe_queue_yumi_i = 1'b1;
        fe_queue_deq_i  = 1'b1;
        consumed++;
      end
      tick();
    end
    idle_inputs();
    check("stream_occ", 128'(occupancy_o), 128'(produced - consumed));

    // Drain, put four back, then reset mid-operation.
    for (int k = 0; k < 20 && rd < mq.size(); k++) begin
      fe_queue_yumi_i = 1'b1;
      fe_queue_deq_i  = 1'b1;
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      fe_queue_v_i = 1'b1;
      fe_queue_i   = make(39'h00a0_0000 + 39'(4 * i));
      tick();
    end
    idle_inputs();
    check("pre_rst_occ", 128'(occupancy_o), 128'd4);
    reset_i = 1'b1;
    tick();
    check("midrst_v", {127'b0, fe_queue_v_o}, 128'd0);
    check("midrst_occ", 128'(occupancy_o), 128'd0);
    check("midrst_ready", {127'b0, fe_queue_ready_o}, 128'd0);
    reset_i = 1'b0;
    #1;
    check("post_rst_ready", {127'b0, fe_queue_ready_o}, 128'd1);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/bp_fe_queue_ckpt_fifo.md
Name: bp_fe_queue_ckpt_fifo

Overview:
- Producer-side FE queue between the FE fetch/exception generator and the BE issue logic.
- Holds fe_queue messages in a circular buffer with three pointers:
  - wptr: enqueue position.
  - rptr: speculative read, advanced by yumi.
  - cptr: checkpoint, advanced by deq.
- Services the BE control set: yumi, clr, roll, deq. Supports replay of read-but-uncommitted entries after a cache miss, and a full flush on suppress.

Parameters:
- bp_params_p, e_bp_inv_cfg, processor configuration; supplies vaddr_width_p and branch_metadata_fwd_width_p.
- els_p, 8, queue depth in entries; power of two, at least 2.
- fe_queue_width_lp, `bp_fe_queue_width(vaddr_width_p, branch_metadata_fwd_width_p), localparam, entry width.
- ptr_width_lp, $clog2(els_p)+1, localparam, pointer width including the wrap bit.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- fe_queue_i  in  fe_queue_width_lp  message from FE.
- fe_queue_v_i  in  1  FE message valid.
- fe_queue_ready_o  out  1  space available; an enqueue occurs when v_i & ready_o.
- fe_queue_o  out  fe_queue_width_lp  entry at rptr.
- fe_queue_v_o  out  1  rptr != wptr.
- fe_queue_yumi_i  in  1  BE consumes the entry at rptr.
- fe_queue_clr_i  in  1  flush all entries.
- fe_queue_roll_i  in  1  restore rptr to cptr (replay).
- fe_queue_deq_i  in  1  commit the oldest entry; cptr advances.
- occupancy_o  out  ptr_width_lp  wptr - cptr, for debug/perf.

Behaviour:
- Reset:
  - wptr, rptr and cptr are all cleared to 0.
  - fe_queue_v_o = 0 and occupancy_o = 0.
  - fe_queue_ready_o = 0 while reset_i is high, and 1 on the first cycle after reset.
- Full and empty are derived from the pointer wrap bits:
  - full = (wptr ^ cptr) == {1'b1, 0...}, i.e. occupancy == els_p.
  - read-empty = (wptr == rptr).
  - The free-slot count counts from cptr, so entries that have been read but not committed are never overwritten.
- fe_queue_ready_o = ~full & ~reset_i. It is independent of the clr/roll/deq inputs, so there is no combinational loop with BE.
- Enqueue:
  - On v_i & ready_o & ~clr_i, mem[wptr] is written and wptr increments.
  - Enqueue-to-v_o latency is 1 cycle; there is no bypass.
- fe_queue_o is a combinational read of mem[rptr[ptr-1:0]]. It is undefined when v_o = 0 and is not required to be zero.
- Yumi: when ~roll_i & ~clr_i, rptr increments.
  - yumi_i & ~v_o is illegal; an assertion fires and the pointer does not move.
- Deq: cptr increments.
  - deq_i when cptr == rptr (the cycle's own yumi included) is illegal; an assertion fires.
- Roll: rptr_next = cptr_next, i.e. cptr after any same-cycle deq.
  - yumi in the same cycle is ignored.
  - Enqueue in the same cycle proceeds.
- Clr has the highest priority:
  - Any same-cycle enqueue, yumi, roll or deq is discarded.
  - rptr and cptr are set to the current wptr, so occupancy becomes 0.
  - ready_o is high next cycle.
- Simultaneous-event resolution:
  - clr > roll > yumi for rptr.
  - deq applies before roll.
  - enqueue is independent of yumi, roll and deq.
- Wrap-around: pointers wrap naturally at 2*els_p; the low bits index storage.
- Reset mid-operation overrides all inputs and discards all entries.

Decomposition:
- Shared package/macros (existing FE-BE interface macros): bp_fe_queue_s, bp_fe_queue_type_e, and the fe_queue width macro. No new package content.
- Natural sub-module: storage via bsg_mem_1r1w (els_p x fe_queue_width_lp, asynchronous read, write-enable = enqueue).
- Pointer logic stays in this module.

Test Plan:
- Reset, then enqueue 8 entries with pc 0x80000000 + 4*i → ready_o drops after the 8th, occupancy_o = 8, and the 9th v_i is held off until a deq.
- Yumi 3 entries, assert roll, then yumi again → fe_queue_o pc sequence is 0x80000000, 0x04, 0x08, 0x80000000; occupancy stays 8.
- Yumi 2, deq 1 with roll in the same cycle → next fe_queue_o pc = 0x80000004; occupancy = 7; ready_o = 1.
- 5 entries resident, clr with simultaneous enqueue, yumi and deq → next cycle v_o = 0, occupancy_o = 0, ready_o = 1; the enqueued message is absent.
- 20 enqueue/yumi/deq rounds crossing wrap at depth 8 → in-order data with no loss or duplication; occupancy never exceeds 8.
- Assert reset_i with 4 entries resident → v_o = 0 and occupancy 0 on the next cycle; ready_o = 0 during reset.
